// File: rtl/pwm_capture.sv
// Bus-mapped PWM input capture. Synchronises an external PWM pin and measures
// its high time and period in clk cycles, exposed as CTRL/STATUS/HIGH/PERIOD registers.
module pwm_capture #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bWData,
  input  logic [31:0] bAddr,
  input  logic        bSel,
  input  logic        bWrite,
  input  logic [1:0]  mem_size,
  output logic [31:0] bRData,
  input  logic        pwmIn
);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

  state_e state_q, state_d;

  logic             s1_q, s2_q, s3_q;
  logic             rise, fall;
  logic             enable_q, enable_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hlat_q, hlat_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] period_q, period_d;

  logic wr_en, wr_ctrl, wr_status;
  logic run_en, arm_start;

  // Only the low nibble of the address and the two STATUS clear bits are decoded.
  logic unused_bits;
  assign unused_bits = ^{bAddr[31:4], bWData[31:2]};

  assign wr_en     = bSel & bWrite & (mem_size == 2'b10);
  assign wr_ctrl   = wr_en & (bAddr[3:0] == 4'h0);
  assign wr_status = wr_en & (bAddr[3:0] == 4'h4);

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable_q) state_d = StArm;
      StArm:   if (rise) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
    // Disabling always discards the measurement in flight.
    if (!enable_q) state_d = StIdle;
  end

  always_comb begin
    run_en    = (state_q == StRun);
    arm_start = (state_q == StArm) & rise;
  end

  always_comb begin
    enable_d = wr_ctrl ? bWData[0] : enable_q;
    valid_d  = valid_q & ~(wr_status & bWData[0]);
    ovf_d    = ovf_q & ~(wr_status & bWData[1]);
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    hlat_d   = hlat_q;
    high_d   = high_q;
    period_d = period_q;

    if (!run_en) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
    if (arm_start) begin
      cnt_d = WIDTH'(1);
    end

    if (run_en) begin
      if (cnt_q == CntMax) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      if (fall) hlat_d = cnt_q;
      // Capture overrides any simultaneous STATUS clear.
      if (rise) begin
        period_d = cnt_q;
        high_d   = hlat_q;
        valid_d  = 1'b1;
        if (sat_q) ovf_d = 1'b1;
        cnt_d    = WIDTH'(1);
        sat_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      enable_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
      hlat_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
    end else begin
      s1_q     <= pwmIn;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      enable_q <= enable_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
      hlat_q   <= hlat_d;
      high_q   <= high_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    bRData = 32'h0;
    case (bAddr[3:0])
      4'h0:    bRData = {31'h0, enable_q};
      4'h4:    bRData = {29'h0, s2_q, ovf_q, valid_q};
      4'h8:    bRData = 32'(high_q);
      4'hC:    bRData = 32'(period_q);
      default: bRData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture: one 16-bit and one 8-bit instance share the bus and pin,
// and a cycle-counting waveform model predicts every register value.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bWData, bAddr;
  logic        bSel, bWrite;
  logic [1:0]  mem_size;
  logic        pwm;
  logic [31:0] rdata16, rdata8;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .bWData(bWData), .bAddr(bAddr), .bSel(bSel), .bWrite(bWrite),
    .mem_size(mem_size), .bRData(rdata16), .pwmIn(pwm)
  );

  pwm_capture #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bWData(bWData), .bAddr(bAddr), .bSel(bSel), .bWrite(bWrite),
    .mem_size(mem_size), .bRData(rdata8), .pwmIn(pwm)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = WIDTH 16, index 1 = WIDTH 8.
  bit exp_en, exp_valid;
  int exp_high[2], exp_period[2];
  bit exp_ovf[2];
  int maxv[2] = '{65535, 255};
  bit prev_ok;
  int run_cyc, hi_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Each clock the pin level is sampled; the model just counts high and total cycles.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      run_cyc++;
      if (pwm) hi_cyc++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] sz);
    bSel = 1'b1; bWrite = 1'b1; bAddr = {28'h0, a}; bWData = d; mem_size = sz;
    step(1);
    bSel = 1'b0; bWrite = 1'b0; mem_size = 2'b00;
  endtask

  function automatic logic [31:0] exp_reg(input int a, input int w);
    case (a)
      0:       return {31'h0, exp_en};
      4:       return {29'h0, pwm, exp_ovf[w], exp_valid};
      8:       return 32'(exp_high[w]);
      12:      return 32'(exp_period[w]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      bAddr = 32'(4 * i);
      #1;
      check($sformatf("%s@%0h/w16", tag, 4 * i), rdata16, exp_reg(4 * i, 0));
      check($sformatf("%s@%0h/w8", tag, 4 * i), rdata8, exp_reg(4 * i, 1));
    end
  endtask

  task automatic capture(input int h, input int p);
    for (int w = 0; w < 2; w++) begin
      exp_high[w]   = (h < maxv[w]) ? h : maxv[w];
      exp_period[w] = (p < maxv[w]) ? p : maxv[w];
      if (p > maxv[w]) exp_ovf[w] = 1'b1;
    end
    exp_valid = 1'b1;
  endtask

  // One PWM period starting with a rise; optionally clear valid in the capture cycle.
  task automatic pulse(input int h, input int l, input bit clr_at_rise = 1'b0);
    pwm = 1'b1;
    if (prev_ok && exp_en) capture(hi_cyc, run_cyc);
    run_cyc = 0;
    hi_cyc  = 0;
    prev_ok = exp_en;
    if (clr_at_rise) begin
      step(2);
      wr(4'h4, 32'h1, 2'b10);
      step(1);
    end else begin
      step(4);
    end
    check_all($sformatf("pulse%0d_%0d", h, l));
    step(h - 4);
    pwm = 1'b0;
    step(l);
  endtask

  task automatic enable_dut();
    wr(4'h0, 32'h1, 2'b10);
    exp_en  = 1'b1;
    prev_ok = 1'b0;
    step(4);
  endtask

  initial begin
    int h, l;
    rst = 1'b1; bSel = 1'b0; bWrite = 1'b0; bAddr = 32'h0; bWData = 32'h0;
    mem_size = 2'b00; pwm = 1'b0;
    exp_en = 1'b0; exp_valid = 1'b0; exp_high = '{0, 0}; exp_period = '{0, 0};
    exp_ovf = '{1'b0, 1'b0}; prev_ok = 1'b0; run_cyc = 0; hi_cyc = 0;
    step(3);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 6; i++) begin
      bAddr = 32'(4 * i);
      #1;
      check($sformatf("rst_rd@%0h/w16", 4 * i), rdata16, 32'h0);
      check($sformatf("rst_rd@%0h/w8", 4 * i), rdata8, 32'h0);
    end
    step(1);

    enable_dut();
    check_all("enabled");
    repeat (4) pulse(25, 75);
    repeat (4) pulse(64, 192);

    wr(4'h4, 32'h2, 2'b10);
    exp_ovf = '{1'b0, 1'b0};
    check_all("ovf_clr");

    pulse(10, 300);
    pulse(10, 20);
    wr(4'h4, 32'h2, 2'b10);
    exp_ovf = '{1'b0, 1'b0};
    check_all("ovf_clr_sat");

    pulse(12, 30, 1'b1);
    wr(4'h4, 32'h1, 2'b10);
    exp_valid = 1'b0;
    check_all("valid_clr");
    wr(4'h0, 32'h0, 2'b00);
    check_all("size_guard");
    wr(4'hC, 32'hFFFF, 2'b10);
    check_all("ro_wr");

    pulse(300, 10);
    pulse(8, 8);

    repeat (20) begin
      h = $urandom_range(5, 120);
      l = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 320) : $urandom_range(4, 200);
      pulse(h, l);
    end

    wr(4'h0, 32'h0, 2'b10);
    exp_en  = 1'b0;
    prev_ok = 1'b0;
    step(3);
    check_all("disabled");
    pulse(20, 30);

    enable_dut();
    pulse(7, 50);
    pulse(33, 40);
    pulse(6, 9);
    pulse(15, 20);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_en = 1'b0; exp_valid = 1'b0; exp_high = '{0, 0}; exp_period = '{0, 0};
    exp_ovf = '{1'b0, 1'b0}; prev_ok = 1'b0;
    check_all("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
